// File: rtl/sfp_drain.sv
// Buffers DEPTH captured col-wide SFP result vectors and streams each one out
// LANES words per beat on a valid/ready interface, flagging dropped strobes.
module sfp_drain #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int LANES   = 2,
  parameter int DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [psum_bw*col-1:0]         in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [psum_bw*LANES-1:0]       out_data,
  output logic                           out_last,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           overflow,
  input  logic                           clr_ovf
);

  localparam int BEATS = col / LANES;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {EMPTY, STREAM} state_t;

  logic [psum_bw*col-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]          count_reg, count_next;
  logic [BW-1:0]          beat_reg;
  logic                   ovf_reg;
  state_t                 state_reg;

  logic                   beat_fire, pop_last, push, drop;
  logic [psum_bw*col-1:0] head;

  assign out_valid = (state_reg == STREAM);
  assign out_last  = out_valid && (beat_reg == BW'(BEATS - 1));
  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign overflow  = ovf_reg;

  assign beat_fire = out_valid && out_ready;
  assign pop_last  = beat_fire && out_last;
  // A strobe landing on the head's final beat may reuse the slot being freed.
  assign push      = in_valid && (!full || pop_last);
  assign drop      = in_valid && full && !pop_last;

  always_comb begin
    count_next = count_reg;
    case ({push, pop_last})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  assign head = mem[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign out_data[gi*psum_bw +: psum_bw] =
        out_valid ? head[(int'(beat_reg) * LANES + gi) * psum_bw +: psum_bw] : '0;
    end
  endgenerate

  // Storage carries no reset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      beat_reg   <= '0;
      ovf_reg    <= 1'b0;
      state_reg  <= EMPTY;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_last) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        beat_reg   <= '0;
      end else if (beat_fire) begin
        beat_reg   <= beat_reg + BW'(1);
      end
      count_reg <= count_next;
      state_reg <= (count_next != '0) ? STREAM : EMPTY;
      if (drop)
        ovf_reg <= 1'b1;
      else if (clr_ovf)
        ovf_reg <= 1'b0;
    end
  end

endmodule
